// File: rtl/cluster_input_assembler_if.sv
// Handshake bundle for cluster_input_assembler.
// Carries the word-stream input and the assembled-vector output.
interface cluster_input_assembler_if #(
    parameter int VEC_W  = 1894,
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [VEC_W-1:0]  out_vec;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_vec
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_vec
    );
endinterface

// File: rtl/cluster_input_assembler.sv
// Assembles 32-bit words into the cluster input vector and holds it for the output-bit modules.
// Define CLUSTER_IN_DBUF_EN for a ping-pong pair of frame buffers.
module cluster_input_assembler #(
    parameter int VEC_W  = 1894,
    parameter int WORD_W = 32,
    parameter int NWORDS = (VEC_W + WORD_W - 1) / WORD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cluster_input_assembler_if.slave bus,
    output logic                     err_pulse,
    output logic [15:0]              frame_cnt
);
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    logic [IDX_W-1:0] widx_q;
    logic [IDX_W-1:0] widx_d;
    logic             err_q;
    logic [15:0]      frame_cnt_q;
    logic [VEC_W-1:0] wmask;
    logic [VEC_W-1:0] wdata;
    logic             wr;
    logic             at_last;
    logic             done;
    logic             ferr;
    logic             xfer;

    // Bits of the final word above VEC_W never reach the mask.
    always_comb begin
        wmask = '0;
        wdata = '0;
        for (int p = 0; p < VEC_W; p++) begin
            if (widx_q == IDX_W'(p / WORD_W)) begin
                wmask[p] = 1'b1;
                wdata[p] = bus.in_data[p % WORD_W];
            end
        end
    end

    assign wr      = bus.in_valid && bus.in_ready;
    assign at_last = (widx_q == LAST_IDX);
    assign done    = wr && at_last && bus.in_last;
    assign ferr    = wr && (at_last != bus.in_last);
    assign xfer    = bus.out_valid && bus.out_ready;

    always_comb begin
        widx_d = widx_q;
        if (wr) begin
            if (at_last || bus.in_last) widx_d = '0;
            else widx_d = widx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx_q      <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            widx_q <= widx_d;
            err_q  <= ferr;
            if (xfer) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign err_pulse = err_q;
    assign frame_cnt = frame_cnt_q;

`ifdef CLUSTER_IN_DBUF_EN
    logic [VEC_W-1:0] buf_a_q;
    logic [VEC_W-1:0] buf_b_q;
    logic [1:0]       full_q;
    logic             fill_sel_q;
    logic             out_sel_q;

    assign bus.in_ready  = ~&full_q;
    assign bus.out_valid = full_q[out_sel_q];
    assign bus.out_vec   = out_sel_q ? buf_b_q : buf_a_q;

    // Fill and present pointers alternate, so frames leave in arrival order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_a_q    <= '0;
            buf_b_q    <= '0;
            full_q     <= 2'b00;
            fill_sel_q <= 1'b0;
            out_sel_q  <= 1'b0;
        end else begin
            if (wr && !fill_sel_q) buf_a_q <= (buf_a_q & ~wmask) | (wdata & wmask);
            if (wr && fill_sel_q) buf_b_q <= (buf_b_q & ~wmask) | (wdata & wmask);
            if (done) begin
                full_q[fill_sel_q] <= 1'b1;
                fill_sel_q         <= ~fill_sel_q;
            end
            if (xfer) begin
                full_q[out_sel_q] <= 1'b0;
                out_sel_q         <= ~out_sel_q;
            end
        end
    end
`else
    typedef enum logic {FILL, HOLD} state_e;

    state_e           state_q;
    logic [VEC_W-1:0] buf_q;

    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_vec   = buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            buf_q   <= '0;
        end else begin
            if (wr) buf_q <= (buf_q & ~wmask) | (wdata & wmask);
            unique case (state_q)
                FILL: if (done) state_q <= HOLD;
                HOLD: if (bus.out_ready) state_q <= FILL;
                default: state_q <= FILL;
            endcase
        end
    end
`endif
endmodule
